// File: rtl/compare_stim_checker.sv
// Board-level stimulus generator and checker for the 4-bit compare block.
// Applies three directed vectors then LFSR vectors, counting comparator mismatches.
module compare_stim_checker #(
    parameter int unsigned N_RANDOM  = 32,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] in1,
    output logic [3:0] in2,
    input  logic       less,
    input  logic       equal,
    input  logic       bigger,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] LAST = 8'(N_RANDOM + 32'd2);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr;
    logic [7:0] idx;
    logic [2:0] expected;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      state_nxt = CHECK;
            CHECK:      state_nxt = (idx == LAST) ? DONE : APPLY;
            default:    state_nxt = IDLE;
        endcase
    end

    // Reference result for the operands currently on the comparator.
    always_comb begin
        if (in1 < in2)       expected = 3'b100;
        else if (in1 == in2) expected = 3'b010;
        else                 expected = 3'b001;
    end

    assign mismatch = ({less, equal, bigger} != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1       <= '0;
            in2       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            lfsr      <= SEED;
            idx       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        done      <= 1'b0;
                        lfsr      <= SEED;
                        idx       <= '0;
                    end
                end
                APPLY: begin
                    busy <= 1'b1;
                    case (idx)
                        8'd0:    begin in1 <= 4'b0000; in2 <= 4'b0000; end
                        8'd1:    begin in1 <= 4'b0101; in2 <= 4'b1010; end
                        8'd2:    begin in1 <= 4'b1111; in2 <= 4'b0001; end
                        default: begin
                            in1  <= lfsr[7:4];
                            in2  <= lfsr[3:0];
                            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        end
                    endcase
                end
                CHECK: begin
                    if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (idx == LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_compare_stim_checker.sv
// Bench for compare_stim_checker: three configurations driven by a faultable comparator
// model, each checked every cycle against a time-indexed behavioural reference.
module tb_compare_stim_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v [3];
    int   mode [3];   // 0 golden, 1 equal stuck 0, 2 less/bigger swapped, 3 random outputs
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] ref3(input logic [7:0] v);
        if (v[7:4] < v[3:0])       return 3'b100;
        else if (v[7:4] == v[3:0]) return 3'b010;
        else                       return 3'b001;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NR = (g == 0) ? 32 : ((g == 1) ? 0 : 4);
        localparam logic [7:0] SEED = (g == 2) ? 8'h00 : 8'hA5;
        localparam int V = 3 + NR;

        logic [3:0] in1, in2;
        logic       less, equal, bigger, busy, done, pass;
        logic [7:0] err;
        logic [2:0] golden, obs;
        logic [2:0] noise = '0;
        logic [7:0] vec [V];

        compare_stim_checker #(.N_RANDOM(NR), .LFSR_SEED(SEED)) dut (
            .clk(clk), .rst(rst), .start(start_v[g]),
            .in1(in1), .in2(in2),
            .less(less), .equal(equal), .bigger(bigger),
            .busy(busy), .done(done), .pass(pass), .err_count(err)
        );

        always @(negedge clk) noise <= 3'($urandom);

        always_comb begin
            golden = ref3({in1, in2});
            case (mode[g])
                1:       obs = golden & 3'b101;
                2:       obs = {golden[0], golden[1], golden[2]};
                3:       obs = noise;
                default: obs = golden;
            endcase
        end
        assign {less, equal, bigger} = obs;

        // Expected vector list straight from the directed table and the LFSR rule.
        initial begin
            logic [7:0] r;
            r = (SEED == 8'h00) ? 8'h01 : SEED;
            vec[0] = 8'h00;
            vec[1] = 8'h5A;
            vec[2] = 8'hF1;
            for (int i = 3; i < V; i++) begin
                vec[i] = r;
                r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
            end
        end

        // Reference: t counts edges since the accepted start; odd t applies, even t checks.
        int         t = 0;
        bit         run = 1'b0;
        logic [3:0] m_in1 = '0, m_in2 = '0;
        bit         m_busy = 1'b0, m_done = 1'b0;
        int         m_err = 0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                t <= 0; run <= 1'b0; m_in1 <= '0; m_in2 <= '0;
                m_busy <= 1'b0; m_done <= 1'b0; m_err <= 0;
            end else if (run) begin
                t <= t + 1;
                if ((t + 1) % 2 == 1) begin
                    {m_in1, m_in2} <= vec[(t + 1) / 2];
                    m_busy <= 1'b1;
                end else begin
                    if ({less, equal, bigger} != ref3(vec[t / 2]) && m_err < 255)
                        m_err <= m_err + 1;
                    if (t + 1 == 2 * V) begin
                        run <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
                    end
                end
            end else if (start_v[g]) begin
                run <= 1'b1; t <= 0; m_err <= 0; m_done <= 1'b0;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("g%0d_in1", g), 32'(in1), 32'(m_in1));
            chk($sformatf("g%0d_in2", g), 32'(in2), 32'(m_in2));
            chk($sformatf("g%0d_busy", g), 32'(busy), 32'(m_busy));
            chk($sformatf("g%0d_done", g), 32'(done), 32'(m_done));
            chk($sformatf("g%0d_err", g), 32'(err), 32'(m_err));
            chk($sformatf("g%0d_pass", g), 32'(pass), 32'(m_done && m_err == 0));
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; mode[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_in1", 32'(gi[0].in1), 0);
        chk("rst_busy", 32'(gi[0].busy), 0);
        chk("rst_err", 32'(gi[0].err), 0);
        chk("rst_pass", 32'(gi[0].pass), 0);
        #2 rst = 1'b0;

        // Golden run on defaults, equal-stuck on N_RANDOM=0, zero seed on the third.
        @(negedge clk);
        mode[1] = 1;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        chk("p1_busy_k", 32'(gi[0].busy), 0);
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("p1_v0", 32'({gi[0].in1, gi[0].in2}), 32'h00);
                chk("p1_busy_k1", 32'(gi[0].busy), 1);
            end
            if (j == 3) chk("p1_v1", 32'({gi[0].in1, gi[0].in2}), 32'h5A);
            if (j == 5) begin
                chk("p1_v2", 32'({gi[0].in1, gi[0].in2}), 32'hF1);
                chk("eq0_done_k5", 32'(gi[1].done), 0);
            end
            if (j == 6) begin
                chk("eq0_done_k6", 32'(gi[1].done), 1);
                chk("eq0_err", 32'(gi[1].err), 1);
                chk("eq0_pass", 32'(gi[1].pass), 0);
            end
            if (j == 7) begin
                chk("p1_r0", 32'({gi[0].in1, gi[0].in2}), 32'hA5);
                chk("seed0_r0", 32'({gi[2].in1, gi[2].in2}), 32'h01);
            end
            if (j == 9)  chk("p1_r1", 32'({gi[0].in1, gi[0].in2}), 32'h4A);
            if (j == 69) chk("p1_done_k69", 32'(gi[0].done), 0);
            if (j == 70) begin
                chk("p1_done_k70", 32'(gi[0].done), 1);
                chk("p1_err", 32'(gi[0].err), 0);
                chk("p1_pass", 32'(gi[0].pass), 1);
            end
        end

        // Swapped outputs on the short config; start held through a noisy default run.
        mode[0] = 3; mode[1] = 2;
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("sw_done_clr", 32'(gi[1].done), 0);
        chk("sw_err_clr", 32'(gi[1].err), 0);
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j == 3) chk("hold_v1", 32'({gi[0].in1, gi[0].in2}), 32'h5A);
            if (j == 6) begin
                chk("sw_err", 32'(gi[1].err), 2);
                chk("sw_pass", 32'(gi[1].pass), 0);
            end
            if (j == 69) chk("hold_done_k69", 32'(gi[0].done), 0);
            if (j == 70) chk("hold_done_k70", 32'(gi[0].done), 1);
        end
        start_v[0] = 1'b0; mode[0] = 0;
        @(negedge clk);
        chk("idle_done", 32'(gi[0].done), 1);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("restart_done", 32'(gi[0].done), 0);
        chk("restart_err", 32'(gi[0].err), 0);

        // Asynchronous reset while vector 10 is on the outputs.
        for (int j = 1; j <= 21; j++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_in1", 32'(gi[0].in1), 0);
        chk("ar_in2", 32'(gi[0].in2), 0);
        chk("ar_busy", 32'(gi[0].busy), 0);
        chk("ar_err", 32'(gi[0].err), 0);
        #1 rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("ar_no_done", 32'(gi[0].done), 0);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (j == 1) chk("replay_busy", 32'(gi[0].busy), 1);
            if (j == 3) chk("replay_v1", 32'({gi[0].in1, gi[0].in2}), 32'h5A);
        end

        // Random starts, comparator faults and occasional asynchronous resets.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 15) == 0);
                mode[i]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
